// File: rtl/core_inst_pkg.sv
// core_inst_pkg: instruction field positions, idle instruction word and sequencer states
package core_inst_pkg;
    localparam int ACC = 33;
    localparam int CEN_PMEM = 32;
    localparam int WEN_PMEM = 31;
    localparam int A_PMEM = 20;
    localparam int CEN_XMEM = 19;
    localparam int WEN_XMEM = 18;
    localparam int A_XMEM = 7;
    localparam int OFIFO_RD = 6;
    localparam int IFIFO_WR = 5;
    localparam int IFIFO_RD = 4;
    localparam int L0_RD = 3;
    localparam int L0_WR = 2;
    localparam int EXECUTE = 1;
    localparam int LOAD = 0;
    localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;
    typedef enum logic [2:0] {IDLE, XLOAD, WREAD, WLOAD, ACT, EXEC, DRAIN, DONE} seqState;
endpackage

// File: rtl/core_inst_seq.sv
// core_inst_seq: drives core inst/D_xmem through XMem fill and the weight-stationary kij loop
module core_inst_seq
    import core_inst_pkg::*;
#(
    parameter int row = 8,
    parameter int col = 8,
    parameter int bw = 4,
    parameter int len_nij = 36,
    parameter int len_kij = 9
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                mode,
    input  logic                host_valid,
    output logic                host_ready,
    input  logic [bw*row-1:0]   host_data,
    input  logic                ofifo_valid,
    output logic [33:0]         inst,
    output logic [bw*row-1:0]   D_xmem,
    output logic                busy,
    output logic                done
);
    localparam int KW = $clog2(len_kij);
    localparam int TOTAL = len_nij + len_kij * col;
    seqState state, stateN;
    logic [9:0] wcnt, wcntN, xaddr;
    logic [KW-1:0] kij, kijN;
    logic [10:0] dcnt, dcntN, pcnt, pcntN, paddrQ;
    logic modeQ, modeN, rdQ, rdN, pwrQ, pwrN, readyN, xcen, xwen;
    logic [33:0] instN;
    logic [bw*row-1:0] dN;
    always_comb begin
        stateN = state;
        wcntN = wcnt;
        kijN = kij;
        dcntN = dcnt;
        pcntN = pcnt + 1'b1;
        modeN = modeQ;
        rdN = 1'b0;
        pwrN = 1'b0;
        readyN = 1'b0;
        dN = D_xmem;
        xaddr = '0;
        xcen = 1'b1;
        xwen = 1'b1;
        instN = IDLE_INST;
        instN[L0_WR] = rdQ;
        // PSUM write trails the ofifo_rd that fetched its vector by one cycle
        if (pwrQ) begin
            instN[CEN_PMEM] = 1'b0;
            instN[WEN_PMEM] = 1'b0;
            instN[A_PMEM +: 11] = paddrQ;
            instN[ACC] = kij != '0;
        end
        case (state)
            IDLE: if (start) begin
                stateN = XLOAD;
                modeN = mode;
                wcntN = '0;
                kijN = '0;
                dcntN = '0;
                pcntN = '0;
                readyN = 1'b1;
            end
            XLOAD: begin
                readyN = 1'b1;
                if (host_valid && host_ready) begin
                    xcen = 1'b0;
                    xwen = 1'b0;
                    xaddr = wcnt;
                    dN = host_data;
                    wcntN = wcnt + 1'b1;
                    if (wcnt == 10'(TOTAL - 1)) begin
                        stateN = WREAD;
                        readyN = 1'b0;
                        pcntN = '0;
                    end
                end
            end
            WREAD: if (pcnt < 11'(col)) begin
                xcen = 1'b0;
                xaddr = 10'(len_nij + int'(kij) * col + int'(pcnt));
                rdN = 1'b1;
            end else begin
                stateN = WLOAD;
                pcntN = '0;
            end
            WLOAD: if (pcnt < 11'(row + col)) begin
                instN[LOAD] = 1'b1;
                instN[L0_RD] = 1'b1;
            end else begin
                stateN = ACT;
                pcntN = '0;
            end
            ACT: if (pcnt < 11'(len_nij)) begin
                xcen = 1'b0;
                xaddr = pcnt[9:0];
                rdN = 1'b1;
            end else begin
                stateN = EXEC;
                pcntN = '0;
            end
            EXEC: begin
                instN[EXECUTE] = 1'b1;
                instN[L0_RD] = 1'b1;
                if (pcnt == 11'(len_nij + row - 1)) begin
                    stateN = DRAIN;
                    dcntN = '0;
                end
            end
            DRAIN: begin
                if (ofifo_valid && dcnt < 11'(len_nij)) begin
                    instN[OFIFO_RD] = 1'b1;
                    pwrN = 1'b1;
                    dcntN = dcnt + 1'b1;
                end
                if (pwrQ && dcnt == 11'(len_nij)) begin
                    stateN = kij == KW'(len_kij - 1) ? DONE : WREAD;
                    kijN = kij == KW'(len_kij - 1) ? kij : kij + 1'b1;
                    pcntN = '0;
                end
            end
            DONE: stateN = IDLE;
            default: stateN = IDLE;
        endcase
        instN[CEN_XMEM] = xcen;
        instN[WEN_XMEM] = xwen;
        instN[A_XMEM +: 11] = {xaddr, modeN};
        instN[IFIFO_WR] = 1'b0;
        instN[IFIFO_RD] = 1'b0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            wcnt <= '0;
            kij <= '0;
            dcnt <= '0;
            pcnt <= '0;
            paddrQ <= '0;
            modeQ <= 1'b0;
            rdQ <= 1'b0;
            pwrQ <= 1'b0;
            inst <= IDLE_INST;
            D_xmem <= '0;
            host_ready <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= stateN;
            wcnt <= wcntN;
            kij <= kijN;
            dcnt <= dcntN;
            pcnt <= pcntN;
            paddrQ <= dcnt;
            modeQ <= modeN;
            rdQ <= rdN;
            pwrQ <= pwrN;
            inst <= instN;
            D_xmem <= dN;
            host_ready <= readyN;
            busy <= stateN != IDLE;
            done <= state == DONE;
        end
    end
endmodule
